// File: rtl/lim_pkg.sv
// Shared types and helpers for the LiM memory datapath: opcode and FSM
// enumerations plus the bitwise LiM operation itself.
package lim_pkg;

  typedef enum logic [1:0] {
    LIM_NONE = 2'd0,
    LIM_XOR  = 2'd1,
    LIM_AND  = 2'd2,
    LIM_OR   = 2'd3
  } lim_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Unknown function codes, and every code when LiM is disabled, behave as NONE.
  function automatic lim_op_e lim_decode(input logic [7:0] funct, input logic lim_en);
    lim_op_e op;
    op = LIM_NONE;
    if (lim_en) begin
      case (funct)
        8'd1:    op = LIM_XOR;
        8'd2:    op = LIM_AND;
        8'd3:    op = LIM_OR;
        default: op = LIM_NONE;
      endcase
    end
    return op;
  endfunction

  function automatic logic [31:0] lim_op(input logic [31:0] a, input logic [31:0] m,
                                         input lim_op_e op);
    logic [31:0] res;
    case (op)
      LIM_XOR: res = a ^ m;
      LIM_AND: res = a & m;
      LIM_OR:  res = a | m;
      default: res = a;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lim_alu.sv
// Combinational LiM unit: applies the opcode to the stored word and merges
// byte lanes for both the store path and the load path.
module lim_alu
  import lim_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_mask,
  input  logic [31:0] i_wdata,
  input  lim_op_e     i_op,
  input  logic [3:0]  i_be,
  output logic [31:0] o_wr_word,
  output logic [31:0] o_rd_word
);

  logic [31:0] w_op_res;
  logic [31:0] w_store_src;

  assign w_op_res    = lim_op(i_word, i_mask, i_op);
  // A plain store writes the bus data; a LiM store writes op(old, mask).
  assign w_store_src = (i_op == LIM_NONE) ? i_wdata : w_op_res;

  always_comb begin
    o_wr_word = i_word;
    o_rd_word = '0;
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        o_wr_word[8*b +: 8] = w_store_src[8*b +: 8];
        o_rd_word[8*b +: 8] = w_op_res[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/lim_mem_datapath.sv
// Racetrack-style word memory with Logic-in-Memory ops; every access is a
// fixed-latency transaction that finishes with a single r_valid_o pulse.
module lim_mem_datapath
  import lim_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int MAX_SIZE     = 256,
  parameter int MEM_MODE     = 1,
  parameter int SHIFT_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clk_m_i,
  input  logic                  Bz_s_i,
  input  logic                  write_pulse_i,
  input  logic                  read_pulse_i,
  input  logic                  en_ab_i,
  input  logic [3:0]            be_b_i,
  input  logic [ADDR_WIDTH-1:0] ADDR_i,
  input  logic [31:0]           write_i_data_i,
  input  logic                  write_en_data_i,
  input  logic [31:0]           mask_i,
  input  logic [7:0]            logic_in_memory_funct_int_i,
  input  logic                  range_active_i,
  output logic [31:0]           r_data_o,
  output logic                  r_valid_o
);

  localparam int WORDS = MAX_SIZE / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(SHIFT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_CYCLES - 2);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic [31:0]      r_mask;
  logic             r_we;
  lim_op_e          r_op;
  logic [31:0]      r_mem [WORDS];

  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_word;
  logic [31:0]      w_wr_word;
  logic [31:0]      w_rd_word;
  lim_op_e          w_op;
  logic             w_unused_ok;

  // Low word-index bits only: the byte offset is dropped and large indices wrap.
  assign w_idx  = ADDR_i[IDX_W+1:2];
  assign w_op   = lim_decode(logic_in_memory_funct_int_i, MEM_MODE != 0);
  assign w_word = r_mem[r_idx];

  // Strobes are informational and range ops are reserved.
  assign w_unused_ok = ^{clk_m_i, Bz_s_i, write_pulse_i, read_pulse_i,
                         range_active_i, ADDR_i[1:0]};

  lim_alu u_alu (
    .i_word    (w_word),
    .i_mask    (r_mask),
    .i_wdata   (r_wdata),
    .i_op      (r_op),
    .i_be      (r_be),
    .o_wr_word (w_wr_word),
    .o_rd_word (w_rd_word)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_we      <= 1'b0;
      r_op      <= LIM_NONE;
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_valid_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en_ab_i) begin
            r_idx   <= w_idx;
            r_be    <= be_b_i;
            r_wdata <= write_i_data_i;
            r_mask  <= mask_i;
            r_we    <= write_en_data_i;
            r_op    <= w_op;
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Models the racetrack shift delay; requests arriving now are dropped.
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (r_we) begin
            r_mem[r_idx] <= w_wr_word;
            r_data_o     <= w_wr_word;
          end else begin
            r_data_o     <= w_rd_word;
          end
          r_valid_o <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lim_mem_datapath.sv
// Directed bench for lim_mem_datapath: standard and LiM loads/stores, byte
// enables, busy-time request rejection and reset abort.
module tb_lim_mem_datapath;

  localparam int SC = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        en_ab_i = 1'b0;
  logic [3:0]  be_b_i = 4'h0;
  logic [7:0]  ADDR_i = 8'h0;
  logic [31:0] write_i_data_i = '0;
  logic        write_en_data_i = 1'b0;
  logic [31:0] mask_i = '0;
  logic [7:0]  funct = 8'h0;
  logic [31:0] r_data_o;
  logic        r_valid_o;

  int n_checks = 0;
  int n_errors = 0;

  lim_mem_datapath #(
    .ADDR_WIDTH(8), .MAX_SIZE(256), .MEM_MODE(1), .SHIFT_CYCLES(SC)
  ) dut (
    .clk_i                       (clk_i),
    .rstn_i                      (rstn_i),
    .clk_m_i                     (1'b0),
    .Bz_s_i                      (1'b0),
    .write_pulse_i               (1'b0),
    .read_pulse_i                (1'b0),
    .en_ab_i                     (en_ab_i),
    .be_b_i                      (be_b_i),
    .ADDR_i                      (ADDR_i),
    .write_i_data_i              (write_i_data_i),
    .write_en_data_i             (write_en_data_i),
    .mask_i                      (mask_i),
    .logic_in_memory_funct_int_i (funct),
    .range_active_i              (1'b0),
    .r_data_o                    (r_data_o),
    .r_valid_o                   (r_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issues one request, waits for its completion and checks data, latency
  // and that the valid pulse is exactly one cycle wide.
  task automatic access(input string tag, input logic we, input logic [7:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] m, input logic [7:0] op,
                        input logic [31:0] exp);
    int cyc;
    en_ab_i = 1'b1; write_en_data_i = we; ADDR_i = addr; be_b_i = be;
    write_i_data_i = wd; mask_i = m; funct = op;
    @(posedge clk_i); #1;
    en_ab_i = 1'b0;
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
      if (r_valid_o) break;
    end
    check({tag, " latency"}, cyc, SC);
    check({tag, " data"}, r_data_o, exp);
    @(posedge clk_i); #1;
    check({tag, " pulse"}, {31'b0, r_valid_o}, 32'h0);
  endtask

  logic [31:0] vec   [5] = '{32'h0, 32'h349B, 32'h6936, 32'h9DD1, 32'hD26C};
  logic [31:0] e_or  [5] = '{32'hF1, 32'h34FB, 32'h69F7, 32'h9DF1, 32'hD2FD};
  logic [31:0] e_and [5] = '{32'h81, 32'h89, 32'h85, 32'h81, 32'h8D};
  logic [31:0] e_xor [5] = '{32'hF0, 32'hF8, 32'hF4, 32'hF0, 32'hFC};
  logic [31:0] r_or  [5] = '{32'hF1, 32'h34FB, 32'h69F7, 32'h9DF1, 32'hD2FD};
  logic [31:0] r_and [5] = '{32'h0, 32'h91, 32'h30, 32'hD1, 32'h60};
  logic [31:0] r_xor [5] = '{32'hF1, 32'h346A, 32'h69C7, 32'h9D20, 32'hD29D};

  initial begin
    int pulses;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset data", r_data_o, 32'h0);
    check("reset valid", {31'b0, r_valid_o}, 32'h0);
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    access("reset mem", 1'b0, 8'd8, 4'hF, 0, 0, 8'd0, 32'h0);

    for (int i = 0; i < 5; i++) access($sformatf("st%0d", i), 1'b1, 8'(4*i), 4'hF, vec[i], 0, 8'd0, vec[i]);
    for (int i = 0; i < 5; i++) access($sformatf("ld%0d", i), 1'b0, 8'(4*i), 4'hF, 0, 0, 8'd0, vec[i]);

    for (int i = 0; i < 5; i++) access($sformatf("st_or%0d", i), 1'b1, 8'(4*i), 4'hF, 0, 32'hF1, 8'd3, e_or[i]);
    for (int i = 0; i < 5; i++) access($sformatf("ld_or%0d", i), 1'b0, 8'(4*i), 4'hF, 0, 0, 8'd0, e_or[i]);
    for (int i = 0; i < 5; i++) access($sformatf("st_and%0d", i), 1'b1, 8'(4*i), 4'hF, 0, 32'h8D, 8'd2, e_and[i]);
    for (int i = 0; i < 5; i++) access($sformatf("ld_and%0d", i), 1'b0, 8'(4*i), 4'hF, 0, 0, 8'd0, e_and[i]);
    for (int i = 0; i < 5; i++) access($sformatf("st_xor%0d", i), 1'b1, 8'(4*i), 4'hF, 0, 32'h71, 8'd1, e_xor[i]);
    for (int i = 0; i < 5; i++) access($sformatf("ld_xor%0d", i), 1'b0, 8'(4*i), 4'hF, 0, 0, 8'd0, e_xor[i]);

    for (int i = 0; i < 5; i++) access($sformatf("rst%0d", i), 1'b1, 8'(4*i), 4'hF, vec[i], 0, 8'd0, vec[i]);
    for (int i = 0; i < 5; i++) access($sformatf("rd_or%0d", i), 1'b0, 8'(4*i), 4'hF, 0, 32'hF1, 8'd3, r_or[i]);
    for (int i = 0; i < 5; i++) access($sformatf("rd_and%0d", i), 1'b0, 8'(4*i), 4'hF, 0, 32'hF1, 8'd2, r_and[i]);
    for (int i = 0; i < 5; i++) access($sformatf("rd_xor%0d", i), 1'b0, 8'(4*i), 4'hF, 0, 32'hF1, 8'd1, r_xor[i]);
    for (int i = 0; i < 5; i++) access($sformatf("intact%0d", i), 1'b0, 8'(4*i), 4'hF, 0, 0, 8'd0, vec[i]);

    // Byte enables, unknown opcode and ignored low address bits.
    access("rd none beF", 1'b0, 8'd4, 4'hF, 0, 32'h8D, 8'd0, 32'h349B);
    access("rd and be1", 1'b0, 8'd4, 4'h1, 0, 32'h8D, 8'd2, 32'h89);
    access("rd and be3", 1'b0, 8'd4, 4'h3, 0, 32'h8D, 8'd2, 32'h0089);
    access("rd opc7", 1'b0, 8'd7, 4'hF, 0, 32'h8D, 8'd7, 32'h349B);
    access("rd be0", 1'b0, 8'd4, 4'h0, 0, 32'h0, 8'd0, 32'h0);
    access("st and be1", 1'b1, 8'd4, 4'h1, 0, 32'h8D, 8'd2, 32'h3489);
    access("st and be2", 1'b1, 8'd4, 4'h2, 0, 32'h8D, 8'd2, 32'h0089);
    access("st none be4", 1'b1, 8'd6, 4'h4, 32'hAABBCCDD, 0, 8'd0, 32'h00BB0089);

    // Re-request while busy must be dropped.
    en_ab_i = 1'b1; write_en_data_i = 1'b0; ADDR_i = 8'd8; be_b_i = 4'hF;
    mask_i = 0; funct = 8'd0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      if (r_valid_o) pulses++;
    end
    en_ab_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_i); #1;
      if (r_valid_o) pulses++;
    end
    check("busy pulses", pulses, 1);
    check("busy data", r_data_o, 32'h6936);

    // Reset in the middle of a store aborts it and clears the array.
    en_ab_i = 1'b1; write_en_data_i = 1'b1; ADDR_i = 8'd8; be_b_i = 4'hF;
    write_i_data_i = 32'hDEADBEEF; funct = 8'd0;
    @(posedge clk_i); #1;
    en_ab_i = 1'b0;
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i); #1;
      if (r_valid_o) pulses++;
    end
    rstn_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i); #1;
      if (r_valid_o) pulses++;
    end
    check("abort pulses", pulses, 0);
    check("abort data", r_data_o, 32'h0);
    access("cleared a8", 1'b0, 8'd8, 4'hF, 0, 0, 8'd0, 32'h0);
    access("cleared a4", 1'b0, 8'd4, 4'hF, 0, 0, 8'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
